// File: rtl/prime_search_if.sv
// Tester and prime-stream signals between prime_search (master) and its environment (slave).
interface prime_search_if #(
   parameter int unsigned WIDTH = 64
) ();
   logic [WIDTH-1:0] test_x;
   logic             test_rst;
   logic             test_composite;
   logic             test_prime;
   logic [WIDTH-1:0] prime_data;
   logic             prime_valid;
   logic             prime_ready;

   modport master (
      output test_x, test_rst, prime_data, prime_valid,
      input  test_composite, test_prime, prime_ready
   );

   modport slave (
      input  test_x, test_rst, prime_data, prime_valid,
      output test_composite, test_prime, prime_ready
   );
endinterface

// File: rtl/prime_search.sv
// Walks odd candidates upward from start_value, runs each through the external
// primality tester and streams accepted primes out on a valid/ready port.
module prime_search #(
   parameter int unsigned WIDTH          = 64,
   parameter int unsigned SETTLE_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH-1:0]    start_value,
   input  logic [15:0]         count,
   input  logic                abort,
   prime_search_if.master      bus,
   output logic                busy,
   output logic                done,
   output logic                exhausted,
   output logic                timeout_err,
   output logic [31:0]         tested_cnt
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned TCNT_W = 32;
   localparam int unsigned SUM_W  = WIDTH + 1;
   localparam int unsigned SW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned WW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_LAST   = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, KICK, WAIT, EMIT, FIN} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   cand_q, cand_d;
   logic [CNT_W-1:0]   remaining_q, remaining_d;
   logic [SW-1:0]      settle_q, settle_d;
   logic [WW-1:0]      wait_q, wait_d;

   logic [WIDTH-1:0]   test_x_d, prime_data_d;
   logic               test_rst_d, prime_valid_d;
   logic               busy_d, done_d, exhausted_d, timeout_d;
   logic [TCNT_W-1:0]  tested_d;

   logic [WIDTH-1:0]   first_cand;
   logic [SUM_W-1:0]   adv_sum;
   logic [WIDTH-1:0]   adv_val;
   logic               adv_carry;
   logic               is_two;
   logic               advance;

   // First candidate: 2 for anything below 2, otherwise the lowest odd value >= start_value
   always_comb begin
      if (start_value < WIDTH'(2)) begin
         first_cand = WIDTH'(2);
      end else if (!start_value[0] && (start_value != WIDTH'(2))) begin
         first_cand = start_value + WIDTH'(1);
      end else begin
         first_cand = start_value;
      end
   end

   assign is_two    = (cand_q == WIDTH'(2));
   assign adv_sum   = {1'b0, cand_q} + SUM_W'(2);
   assign adv_val   = is_two ? WIDTH'(3) : adv_sum[WIDTH-1:0];
   assign adv_carry = !is_two && adv_sum[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cand_d        = cand_q;
      remaining_d   = remaining_q;
      settle_d      = settle_q;
      wait_d        = wait_q;
      test_x_d      = bus.test_x;
      test_rst_d    = bus.test_rst;
      prime_data_d  = bus.prime_data;
      prime_valid_d = bus.prime_valid;
      busy_d        = busy;
      done_d        = 1'b0;
      exhausted_d   = exhausted;
      timeout_d     = timeout_err;
      tested_d      = tested_cnt;
      advance       = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               busy_d      = 1'b1;
               exhausted_d = 1'b0;
               timeout_d   = 1'b0;
               tested_d    = '0;
               cand_d      = first_cand;
               remaining_d = count;
               if (count == CNT_W'(0)) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else if (first_cand == WIDTH'(2)) begin
                  state_d       = EMIT;
                  prime_valid_d = 1'b1;
                  prime_data_d  = first_cand;
               end else begin
                  state_d    = KICK;
                  test_x_d   = first_cand;
                  test_rst_d = 1'b1;
                  settle_d   = '0;
                  tested_d   = TCNT_W'(1);
               end
            end
         end

         KICK: begin
            if (settle_q == SETTLE_LAST) begin
               state_d    = WAIT;
               test_rst_d = 1'b0;
               wait_d     = '0;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end

         // First WAIT cycle is skipped: the tester's flags are not meaningful right after restart
         WAIT: begin
            if ((wait_q != '0) && bus.test_composite) begin
               advance = 1'b1;
            end else if ((wait_q != '0) && bus.test_prime) begin
               state_d       = EMIT;
               prime_valid_d = 1'b1;
               prime_data_d  = cand_q;
            end else if (wait_q == WAIT_LAST) begin
               timeout_d = 1'b1;
               advance   = 1'b1;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end

         EMIT: begin
            if (bus.prime_ready) begin
               prime_valid_d = 1'b0;
               remaining_d   = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else begin
                  advance = 1'b1;
               end
            end
         end

         FIN: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Shared candidate advance for rejects, timeouts and handshakes
      if (advance) begin
         if (adv_carry) begin
            exhausted_d = 1'b1;
            state_d     = FIN;
            done_d      = 1'b1;
         end else begin
            cand_d     = adv_val;
            state_d    = KICK;
            test_x_d   = adv_val;
            test_rst_d = 1'b1;
            settle_d   = '0;
            tested_d   = tested_cnt + TCNT_W'(1);
         end
      end

      if (busy && abort) begin
         state_d       = IDLE;
         prime_valid_d = 1'b0;
         busy_d        = 1'b0;
         done_d        = 1'b0;
      end

      if ((state_d == FIN) || (state_d == IDLE)) begin
         test_rst_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_q          <= '0;
         remaining_q     <= '0;
         settle_q        <= '0;
         wait_q          <= '0;
         bus.test_x      <= '0;
         bus.test_rst    <= 1'b1;
         bus.prime_data  <= '0;
         bus.prime_valid <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         exhausted       <= 1'b0;
         timeout_err     <= 1'b0;
         tested_cnt      <= '0;
      end else begin
         cand_q          <= cand_d;
         remaining_q     <= remaining_d;
         settle_q        <= settle_d;
         wait_q          <= wait_d;
         bus.test_x      <= test_x_d;
         bus.test_rst    <= test_rst_d;
         bus.prime_data  <= prime_data_d;
         bus.prime_valid <= prime_valid_d;
         busy            <= busy_d;
         done            <= done_d;
         exhausted       <= exhausted_d;
         timeout_err     <= timeout_d;
         tested_cnt      <= tested_d;
      end
   end

endmodule

// File: doc/prime_search.md
# prime_search

Candidate generator and sequencer for the primality tester. Given a start value and a count, it walks odd candidates upward. Each candidate goes to an external tester (64-bit `x` in, composite flag `Y` and prime flag `ret` out; tester restarts on its `rst`). Each accepted prime is emitted on a valid/ready stream. The block sits in front of the tester: it drives the tester's inputs and consumes its verdicts.

## Interface
- `WIDTH`, 64: candidate / prime width
- `SETTLE_CYCLES`, 2: cycles `test_rst` is held high per candidate (≥1)
- `TIMEOUT_CYCLES`, 4096: max cycles waiting for a verdict before the candidate is skipped
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: begin a search; honoured only while `busy`=0
- `start_value` in WIDTH: lowest value to consider
- `count` in 16: number of primes to emit
- `abort` in 1: cancel the current search
- `test_x` out WIDTH: candidate to tester
- `test_rst` out 1: tester restart
- `test_composite` in 1: tester `Y`
- `test_prime` in 1: tester `ret`
- `prime_data` out WIDTH: emitted prime
- `prime_valid` out 1: `prime_data` valid
- `prime_ready` in 1: consumer accepts
- `busy` out 1: search in progress
- `done` out 1: one-cycle pulse at end of search
- `exhausted` out 1: last search ran past 2^WIDTH−1
- `timeout_err` out 1: sticky per search; at least one verdict timed out
- `tested_cnt` out 32: candidates tested in the current/last search

## Operation
- FSM states: IDLE, KICK, WAIT, EMIT, FIN.
- **IDLE:** `test_rst`=1 and `busy`=0.
- **Start:** `start` in IDLE loads the candidate and clears `exhausted`, `timeout_err` and `tested_cnt`.
  - `start_value`<2 → candidate 2.
  - Even value >2 → `start_value`+1.
  - Otherwise → `start_value`.
  - `count`=0 → go to FIN. Otherwise remaining=`count`.
  - Candidate 2 → go to EMIT directly (2 is never sent to the tester). Otherwise go to KICK.
- **KICK:** `test_x`=candidate, `test_rst`=1 for SETTLE_CYCLES cycles, then WAIT. `tested_cnt` increments on entry.
- **WAIT:** `test_rst`=0 and `test_x` is held.
  - Verdicts are sampled from the 2nd WAIT cycle onward, so the tester's post-reset flags are ignored.
  - `test_composite`=1 → reject. Composite wins if both flags are high.
  - Else `test_prime`=1 → accept and go to EMIT.
  - Wait counter reaches TIMEOUT_CYCLES → set `timeout_err` and reject.
- **Reject / advance:**
  - Candidate 2 advances to 3; any other candidate advances by 2.
  - Carry out of WIDTH bits → set `exhausted` and go to FIN.
  - Otherwise go to KICK.
- **EMIT:** `prime_valid`=1 and `prime_data`=candidate, both held stable until `prime_ready`. On the handshake, remaining decrements and the candidate advances as above. remaining=0 → FIN, else KICK.
- **FIN:** `done`=1 for one cycle, then IDLE.
- **`abort`:** has priority over everything when `busy`=1. Next state is IDLE, `prime_valid` drops the next cycle, and no `done` pulse is issued.
- `start` while `busy`=1 is ignored.

## Timing
- Reset values:
  - `prime_data`, `test_x`, `tested_cnt` = 0
  - `prime_valid`, `busy`, `done`, `exhausted`, `timeout_err` = 0
  - `test_rst` = 1
  - state = IDLE
- `start` sampled at edge N → `busy`=1 and `test_rst`=1 with the candidate on `test_x` from cycle N+1.
- `test_rst` falls at N+1+SETTLE_CYCLES.
- Verdict seen at edge M:
  - Accept → `prime_valid` from M+1.
  - Reject → next KICK from M+1.
- Handshake at edge H, last prime → `done` high in cycle H+1, `busy`=0 from H+2.
- `exhausted` and `timeout_err` hold until the next accepted `start`.
- Async `rst` mid-search → outputs return to reset values immediately; no `done` pulse.

## Test plan
- Behavioural tester (fixed 20-cycle verdict latency, exact primality), `start_value`=10, `count`=3, `prime_ready`=1 → 11, 13, 17 emitted; `tested_cnt`=4; one `done` pulse.
- `start_value`=0, `count`=2 → 2 (no KICK), then 3; the tester sees only `test_x`=3.
- `start_value`=2^64−58, `count`=1 → 2^64−57…2^64−1 all rejected; `exhausted`=1, no `prime_valid`, `done` pulse, `tested_cnt`=29.
- Tester never responds, `TIMEOUT_CYCLES`=64, `start_value`=9, `count`=1 → each candidate skipped after 64 cycles and `timeout_err`=1; then `abort` → IDLE, `test_rst`=1, no `done`.
- `start_value`=100, `count`=1, `prime_ready` low for 5 cycles → `prime_data`=101 stable, `prime_valid` held; accepted on the 6th cycle.
- Async `rst` asserted during WAIT, and `start` pulsed while busy → reset values immediately; the busy-time `start` is ignored.
